// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution row sequencer.
//   state_t      : sequencer FSM states
//   KERNEL_TAPS  : number of kernel weights loaded per pass
//   STRIDE_1/2   : legal window stride encodings
//   n_out()      : number of output rows for a given image height and stride
//   stride_ok()  : true for a legal stride encoding
package conv_pkg;

  localparam int KERNEL_TAPS = 9;

  localparam logic [1:0] STRIDE_1 = 2'd1;
  localparam logic [1:0] STRIDE_2 = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KLOAD,
    ST_LOAD,
    ST_CONV_GO,
    ST_CONV_WAIT,
    ST_NEXT,
    ST_FIN
  } state_t;

  // Output rows produced by a 3-row window sliding down 'rows' image rows.
  function automatic int n_out(input int rows, input int stride);
    return (rows - 3) / stride + 1;
  endfunction

  function automatic logic stride_ok(input logic [1:0] stride);
    return (stride == STRIDE_1) || (stride == STRIDE_2);
  endfunction

endpackage

// File: rtl/mem_row_loader.sv
// Generic sequential-read / lagged-write engine.
// While 'run' is high it issues num_reads reads (index 0..num_reads-1, one per
// cycle) and then spends one drain cycle, during which 'done' is high. Every
// read is mirrored one cycle later on the write side, carrying the index and a
// row/column split of that index (ROW_LEN entries per row). Memory data with a
// 1-cycle latency therefore lines up with wr_en without further buffering.
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   run              level: engine active (drops to 0 to clear it)
//   num_reads        number of reads to issue
//   base_addr        address of index 0
//   rd_en, rd_addr   read strobe and address (base_addr + count)
//   count            current read index
//   wr_en, wr_idx    write strobe and index of the read being written back
//   wr_row, wr_col   row/column split of wr_idx
//   done             high during the drain cycle
module mem_row_loader #(
  parameter int AW      = 10,
  parameter int CW      = 7,
  parameter int ROW_LEN = 28,
  parameter int ROW_W   = 2,
  parameter int COL_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [CW-1:0]    num_reads,
  input  logic [AW-1:0]    base_addr,
  output logic             rd_en,
  output logic [AW-1:0]    rd_addr,
  output logic [CW-1:0]    count,
  output logic             wr_en,
  output logic [CW-1:0]    wr_idx,
  output logic [ROW_W-1:0] wr_row,
  output logic [COL_W-1:0] wr_col,
  output logic             done
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_LEN - 1);

  logic [CW-1:0]    idx;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;

  assign count   = idx;
  assign rd_en   = run && (idx < num_reads);
  assign done    = run && (idx == num_reads);
  assign rd_addr = base_addr + AW'(idx);

  // Read-side counters. Clearing on 'done' lets a back-to-back second job
  // (kernel load followed directly by a row load) start again from index 0.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx <= '0;
      row <= '0;
      col <= '0;
    end else if (!run || done) begin
      idx <= '0;
      row <= '0;
      col <= '0;
    end else if (rd_en) begin
      idx <= idx + CW'(1);
      if (col == COL_LAST) begin
        col <= '0;
        row <= row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Write side: a one-cycle delayed copy of the read side.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en  <= 1'b0;
      wr_idx <= '0;
      wr_row <= '0;
      wr_col <= '0;
    end else begin
      wr_en  <= rd_en;
      wr_idx <= idx;
      wr_row <= row;
      wr_col <= col;
    end
  end

endmodule

// File: rtl/conv_row_sequencer.sv
// Controller for one 3x3 convolution pass over a stored image.
// Loads the 9 kernel weights into the kernel register, then for every output
// row reloads the 3-row line buffer from image memory, kicks the convolve
// engine and waits for it, advancing the window by the configured stride.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   start, cfg_stride             pass request (IDLE only) and stride (1 or 2)
//   img_rd_en/addr/data           image memory read port (1-cycle latency)
//   kmem_rd_en/addr/data          kernel memory read port (1-cycle latency)
//   k_wr_en/addr/data             kernel register write port
//   lb_wr_en/row_sel/wr_col/data  line buffer write port
//   conv_start/stride/dest_base   convolve engine kick and its arguments
//   conv_done                     convolve completion pulse
//   busy, done, err               status: active, end-of-pass, bad stride
module conv_row_sequencer
  import conv_pkg::*;
#(
  parameter int BIT_DEPTH = 8,
  parameter int IMG_ROWS  = 28,
  parameter int COLS      = 28,
  parameter int IMG_AW    = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           cfg_stride,
  output logic                 img_rd_en,
  output logic [IMG_AW-1:0]    img_rd_addr,
  input  logic [BIT_DEPTH-1:0] img_rd_data,
  output logic                 kmem_rd_en,
  output logic [3:0]           kmem_rd_addr,
  input  logic [BIT_DEPTH-1:0] kmem_rd_data,
  output logic                 k_wr_en,
  output logic [3:0]           k_wr_addr,
  output logic [BIT_DEPTH-1:0] k_wr_data,
  output logic                 lb_wr_en,
  output logic [1:0]           lb_row_sel,
  output logic [4:0]           lb_wr_col,
  output logic [BIT_DEPTH-1:0] lb_wr_data,
  output logic                 conv_start,
  output logic [1:0]           conv_stride,
  output logic [4:0]           conv_dest_base,
  input  logic                 conv_done,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int LB_READS = 3 * COLS;
  localparam int CW       = $clog2(LB_READS + KERNEL_TAPS + 1);

  localparam logic [CW-1:0] KLOAD_READS = CW'(KERNEL_TAPS);
  localparam logic [CW-1:0] LOAD_READS  = CW'(LB_READS);
  localparam logic [4:0]    LAST_ROW_S1 = 5'(n_out(IMG_ROWS, 1) - 1);
  localparam logic [4:0]    LAST_ROW_S2 = 5'(n_out(IMG_ROWS, 2) - 1);

  state_t     state, state_nx;
  logic [4:0] out_row;
  logic [1:0] stride_q;
  logic       err_q;

  logic in_kload, in_load, accept;
  logic at_last;

  logic [IMG_AW-1:0] top_row, row_base;

  logic              ld_rd_en, ld_wr_en, ld_done;
  logic [IMG_AW-1:0] ld_rd_addr;
  logic [CW-1:0]     ld_count, ld_wr_idx, ld_num;
  logic [1:0]        ld_wr_row;
  logic [4:0]        ld_wr_col;

  assign in_kload = (state == ST_KLOAD);
  assign in_load  = (state == ST_LOAD);
  assign accept   = (state == ST_IDLE) && start && stride_ok(cfg_stride);
  assign at_last  = (out_row == ((stride_q == STRIDE_2) ? LAST_ROW_S2 : LAST_ROW_S1));

  // The three window rows are contiguous in row-major memory, so one linear
  // run of 3*COLS reads starting at top*COLS covers the whole row-set.
  assign top_row  = IMG_AW'(out_row) * IMG_AW'(stride_q);
  assign row_base = top_row * IMG_AW'(COLS);
  assign ld_num   = in_kload ? KLOAD_READS : LOAD_READS;

  mem_row_loader #(
    .AW      (IMG_AW),
    .CW      (CW),
    .ROW_LEN (COLS),
    .ROW_W   (2),
    .COL_W   (5)
  ) u_loader (
    .clk       (clk),
    .rst       (rst),
    .run       (in_kload || in_load),
    .num_reads (ld_num),
    .base_addr (row_base),
    .rd_en     (ld_rd_en),
    .rd_addr   (ld_rd_addr),
    .count     (ld_count),
    .wr_en     (ld_wr_en),
    .wr_idx    (ld_wr_idx),
    .wr_row    (ld_wr_row),
    .wr_col    (ld_wr_col),
    .done      (ld_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    // NOTE: the default assignment first guarantees state_nx is written on
    // every path, so no latch is inferred for the arms that hold state.
    state_nx = state;
    case (state)
      ST_IDLE:      if (accept)    state_nx = ST_KLOAD;
      ST_KLOAD:     if (ld_done)   state_nx = ST_LOAD;
      ST_LOAD:      if (ld_done)   state_nx = ST_CONV_GO;
      ST_CONV_GO:                  state_nx = ST_CONV_WAIT;
      ST_CONV_WAIT: if (conv_done) state_nx = ST_NEXT;
      ST_NEXT:                     state_nx = at_last ? ST_FIN : ST_LOAD;
      ST_FIN:                      state_nx = ST_IDLE;
      default:                     state_nx = ST_IDLE;
    endcase
  end

  // Pass context: stride is frozen at accept so a later cfg_stride change
  // cannot disturb a pass in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_row  <= '0;
      stride_q <= STRIDE_1;
      err_q    <= 1'b0;
    end else begin
      err_q <= (state == ST_IDLE) && start && !stride_ok(cfg_stride);
      if (accept) begin
        stride_q <= cfg_stride;
        out_row  <= '0;
      end else if ((state == ST_NEXT) && !at_last) begin
        out_row <= out_row + 5'd1;
      end
    end
  end

  // Memory and write ports are gated by state; addresses and data are forced
  // to zero whenever their strobe is low.
  assign kmem_rd_en   = in_kload && ld_rd_en;
  assign kmem_rd_addr = kmem_rd_en ? 4'(ld_count) : 4'd0;
  assign k_wr_en      = in_kload && ld_wr_en;
  assign k_wr_addr    = k_wr_en ? 4'(ld_wr_idx) : 4'd0;
  assign k_wr_data    = k_wr_en ? kmem_rd_data : '0;

  assign img_rd_en    = in_load && ld_rd_en;
  assign img_rd_addr  = img_rd_en ? ld_rd_addr : '0;
  assign lb_wr_en     = in_load && ld_wr_en;
  assign lb_row_sel   = lb_wr_en ? ld_wr_row : 2'd0;
  assign lb_wr_col    = lb_wr_en ? ld_wr_col : 5'd0;
  assign lb_wr_data   = lb_wr_en ? img_rd_data : '0;

  assign conv_start     = (state == ST_CONV_GO);
  assign conv_stride    = stride_q;
  assign conv_dest_base = out_row;

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_FIN);
  assign err  = err_q;

endmodule

// File: tb/tb_conv_row_sequencer.sv
module tb_conv_row_sequencer;

  localparam int BD     = 8;
  localparam int ROWS   = 5;
  localparam int C      = 4;
  localparam int AW     = 5;
  localparam int BUDGET = 400;

  logic          clk, rst, start;
  logic [1:0]    cfg_stride;
  logic          img_rd_en, kmem_rd_en, k_wr_en, lb_wr_en;
  logic [AW-1:0] img_rd_addr;
  logic [BD-1:0] img_rd_data, kmem_rd_data, k_wr_data, lb_wr_data;
  logic [3:0]    kmem_rd_addr, k_wr_addr;
  logic [1:0]    lb_row_sel, conv_stride;
  logic [4:0]    lb_wr_col, conv_dest_base;
  logic          conv_start, conv_done, busy, done, err;

  conv_row_sequencer #(
    .BIT_DEPTH (BD),
    .IMG_ROWS  (ROWS),
    .COLS      (C),
    .IMG_AW    (AW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .cfg_stride     (cfg_stride),
    .img_rd_en      (img_rd_en),
    .img_rd_addr    (img_rd_addr),
    .img_rd_data    (img_rd_data),
    .kmem_rd_en     (kmem_rd_en),
    .kmem_rd_addr   (kmem_rd_addr),
    .kmem_rd_data   (kmem_rd_data),
    .k_wr_en        (k_wr_en),
    .k_wr_addr      (k_wr_addr),
    .k_wr_data      (k_wr_data),
    .lb_wr_en       (lb_wr_en),
    .lb_row_sel     (lb_row_sel),
    .lb_wr_col      (lb_wr_col),
    .lb_wr_data     (lb_wr_data),
    .conv_start     (conv_start),
    .conv_stride    (conv_stride),
    .conv_dest_base (conv_dest_base),
    .conv_done      (conv_done),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memories with 1-cycle read latency; garbage when not read.
  logic [BD-1:0] img_mem [0:(1<<AW)-1];
  logic [BD-1:0] kmem    [0:15];

  always @(posedge clk) begin
    img_rd_data  <= img_rd_en  ? img_mem[img_rd_addr] : BD'($urandom);
    kmem_rd_data <= kmem_rd_en ? kmem[kmem_rd_addr]   : BD'($urandom);
  end

  // Convolve engine model: conv_done exactly conv_w cycles after conv_start.
  int   conv_w;
  int   wcnt;
  logic model_done, spur;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt       <= 0;
      model_done <= 1'b0;
    end else if (conv_start) begin
      wcnt       <= conv_w - 1;
      model_done <= (conv_w == 1);
    end else if (wcnt != 0) begin
      wcnt       <= wcnt - 1;
      model_done <= (wcnt == 1);
    end else begin
      model_done <= 1'b0;
    end
  end

  assign conv_done = model_done | spur;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Observed / expected events: n = cycle index since start, then up to
  // three payload fields.
  typedef struct {
    int n;
    int a;
    int b;
    int d;
  } ev_t;

  ev_t kr_q[$], kw_q[$], ir_q[$], lw_q[$], cs_q[$];
  ev_t kr_e[$], kw_e[$], ir_e[$], lw_e[$], cs_e[$];
  int  done_n, err_cnt, idle_cnt;

  function automatic logic [63:0] pack(input ev_t e);
    return {16'(e.n), 16'(e.a), 16'(e.b), 16'(e.d)};
  endfunction

  task automatic compare_q(input string tag, input ev_t got[$], input ev_t exp[$]);
    int m;
    check({tag, "_count"}, 64'(got.size()), 64'(exp.size()));
    m = (got.size() < exp.size()) ? got.size() : exp.size();
    for (int i = 0; i < m; i++)
      check($sformatf("%s[%0d]", tag, i), pack(got[i]), pack(exp[i]));
  endtask

  // Reference: pass timeline from the state durations (start cycle = 0,
  // kernel load cycles 1..10, then N_OUT row-sets of LOAD+GO+WAIT+NEXT).
  task automatic expect_pass(input int s, input int w);
    int nout, per, l0, addr;
    kr_e.delete(); kw_e.delete(); ir_e.delete(); lw_e.delete(); cs_e.delete();
    nout = (ROWS - 3) / s + 1;
    per  = (3 * C + 1) + 1 + w + 1;
    for (int i = 0; i < 9; i++) begin
      kr_e.push_back('{1 + i, i, 0, 0});
      kw_e.push_back('{2 + i, i, 0, int'(kmem[i])});
    end
    for (int r = 0; r < nout; r++) begin
      l0 = 11 + r * per;
      for (int rr = 0; rr < 3; rr++)
        for (int c = 0; c < C; c++) begin
          addr = (r * s + rr) * C + c;
          ir_e.push_back('{l0 + rr * C + c, addr, 0, 0});
          lw_e.push_back('{l0 + rr * C + c + 1, rr, c, int'(img_mem[addr])});
        end
      cs_e.push_back('{l0 + 3 * C + 1, r, s, 0});
    end
    compare_q("kmem_rd", kr_q, kr_e);
    compare_q("k_wr", kw_q, kw_e);
    compare_q("img_rd", ir_q, ir_e);
    compare_q("lb_wr", lw_q, lw_e);
    compare_q("conv_start", cs_q, cs_e);
    check("pass_cycles", 64'(done_n + 1), 64'(1 + 10 + nout * per + 1));
    check("pass_err", 64'(err_cnt), 64'd0);
    check("pass_busy_low", 64'(idle_cnt), 64'd0);
  endtask

  // One pass; with 'inject' a start (other stride) is raised in the first
  // CONV_WAIT cycle and a spurious conv_done in the first cycle of each LOAD.
  task automatic run_pass(input logic [1:0] s, input int w, input bit inject);
    int n;
    bit finished, prev_cs, prev_rd;
    kr_q.delete(); kw_q.delete(); ir_q.delete(); lw_q.delete(); cs_q.delete();
    done_n = -1; err_cnt = 0; idle_cnt = 0;
    conv_w = w;
    @(negedge clk);
    start = 1'b1;
    cfg_stride = s;
    n = 0; finished = 1'b0; prev_cs = 1'b0; prev_rd = 1'b0;
    while (!finished && n < BUDGET) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      spur  = 1'b0;
      cfg_stride = s;
      if (kmem_rd_en) kr_q.push_back('{n, int'(kmem_rd_addr), 0, 0});
      if (k_wr_en)    kw_q.push_back('{n, int'(k_wr_addr), 0, int'(k_wr_data)});
      if (img_rd_en)  ir_q.push_back('{n, int'(img_rd_addr), 0, 0});
      if (lb_wr_en)   lw_q.push_back('{n, int'(lb_row_sel), int'(lb_wr_col), int'(lb_wr_data)});
      if (conv_start) cs_q.push_back('{n, int'(conv_dest_base), int'(conv_stride), 0});
      if (err)   err_cnt++;
      if (!busy) idle_cnt++;
      if (done) begin
        finished = 1'b1;
        done_n = n;
      end
      if (inject && !finished) begin
        if (prev_cs) begin
          start = 1'b1;
          cfg_stride = (s == 2'd1) ? 2'd2 : 2'd1;
        end
        if (img_rd_en && !prev_rd) spur = 1'b1;
      end
      prev_cs = conv_start;
      prev_rd = img_rd_en;
    end
    check("done_seen", 64'(finished), 64'd1);
    @(negedge clk);
    check("idle_after_done", {busy, done}, 64'd0);
    expect_pass(int'(s), w);
  endtask

  task automatic illegal_start(input logic [1:0] s);
    int rd;
    rd = 0;
    @(negedge clk);
    start = 1'b1;
    cfg_stride = s;
    @(negedge clk);
    start = 1'b0;
    cfg_stride = 2'd1;
    check($sformatf("err_pulse_s%0d", s), {err, busy}, 64'b10);
    rd += int'(img_rd_en | kmem_rd_en);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rd += int'(img_rd_en | kmem_rd_en | busy | err);
    end
    check($sformatf("err_quiet_s%0d", s), 64'(rd), 64'd0);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({img_rd_en, img_rd_addr, kmem_rd_en, kmem_rd_addr, k_wr_en, k_wr_addr,
                k_wr_data, lb_wr_en, lb_row_sel, lb_wr_col, lb_wr_data, conv_start,
                conv_dest_base, busy, done, err});
  endfunction

  task automatic fill_directed();
    for (int a = 0; a < (1 << AW); a++) img_mem[a] = BD'(a);
    for (int i = 0; i < 16; i++) kmem[i] = BD'(i + 1);
  endtask

  task automatic fill_random();
    for (int a = 0; a < (1 << AW); a++) img_mem[a] = BD'($urandom);
    for (int i = 0; i < 16; i++) kmem[i] = BD'($urandom);
  endtask

  initial begin
    bit seen;
    int quiet;
    rst = 1'b0;
    start = 1'b0;
    cfg_stride = 2'd1;
    spur = 1'b0;
    conv_w = 3;
    fill_directed();
    repeat (2) @(negedge clk);
    check("reset_outs", all_outs(), 64'd0);
    check("reset_conv_stride", 64'(conv_stride), 64'd1);
    rst = 1'b1;
    @(negedge clk);

    // Reset in the middle of LOAD of a stride-2 pass.
    start = 1'b1;
    cfg_stride = 2'd2;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (img_rd_en) seen = 1'b1;
    end
    check("load_reached", 64'(seen), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("midpass_reset_outs", all_outs(), 64'd0);
    check("midpass_reset_stride", 64'(conv_stride), 64'd1);
    quiet = 0;
    repeat (2) begin
      @(negedge clk);
      quiet += int'(k_wr_en | lb_wr_en | img_rd_en | kmem_rd_en | busy);
    end
    check("reset_quiet", 64'(quiet), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    run_pass(2'd1, 3, 1'b0);
    run_pass(2'd2, 3, 1'b0);
    illegal_start(2'd0);
    illegal_start(2'd3);
    run_pass(2'd1, 3, 1'b1);

    for (int k = 0; k < 6; k++) begin
      fill_random();
      run_pass(2'($urandom_range(1, 2)), int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_row_sequencer.md
Name: conv_row_sequencer

Overview:
- Top-level controller for one 3x3 convolution pass over a stored image.
- Loads the 9 kernel weights into the kernel register, then repeatedly fills the 3-row line buffer from image memory.
- For each row-set it triggers the convolve engine and waits for its done.
- Advances the window by the configured stride until every output row is produced.
- Sits between the image/kernel memories and the line buffer, kernel register and convolve instances.

Parameters:
- BIT_DEPTH, 8, data word width for image, kernel and line-buffer data.
- IMG_ROWS, 28, number of input image rows (minimum 3).
- COLS, 28, image width; equals the line-buffer column count.
- IMG_AW, 10, image memory address width; must satisfy 2^IMG_AW >= IMG_ROWS*COLS.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a pass; sampled only in IDLE.
- cfg_stride  in  2  window stride; 1 or 2 valid, 0 and 3 illegal.
- img_rd_en  out  1  image memory read strobe.
- img_rd_addr  out  IMG_AW  image address = row*COLS+col.
- img_rd_data  in  BIT_DEPTH  image data, valid exactly 1 cycle after img_rd_en.
- kmem_rd_en  out  1  kernel memory read strobe.
- kmem_rd_addr  out  4  kernel memory address, 0..8.
- kmem_rd_data  in  BIT_DEPTH  kernel data, 1-cycle latency.
- k_wr_en  out  1  kernel register write enable.
- k_wr_addr  out  4  kernel register index.
- k_wr_data  out  BIT_DEPTH  kernel register data.
- lb_wr_en  out  1  line buffer write enable.
- lb_row_sel  out  2  target line-buffer row, 0..2.
- lb_wr_col  out  5  target column.
- lb_wr_data  out  BIT_DEPTH  write data.
- conv_start  out  1  one-cycle start pulse to convolve.
- conv_stride  out  2  stride latched at start.
- conv_dest_base  out  5  output row index for this row-set.
- conv_done  in  1  convolve completion pulse.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of pass.
- err  out  1  one-cycle pulse when start arrives with an illegal stride.

Behaviour:
- Reset (rst=0, asynchronous): FSM goes to IDLE; all counters are 0; every output is 0, except conv_stride, which resets to 1.
- FSM states: IDLE, KLOAD, LOAD, CONV_GO, CONV_WAIT, NEXT, FIN.
- IDLE:
  - start with cfg_stride in {1,2}: latch the stride, clear out_row, go to KLOAD next cycle.
  - start with an illegal stride: pulse err the next cycle, stay in IDLE.
- KLOAD:
  - Issues kmem reads for addresses 0..8 on consecutive cycles.
  - Each returned word is written 1 cycle later with k_wr_addr equal to the read address.
  - The state lasts 10 cycles: 9 issue cycles plus 1 drain cycle. Then go to LOAD.
- LOAD:
  - top = out_row*stride.
  - Reads rows top, top+1, top+2, columns 0..COLS-1, row-major, one read per cycle.
  - Line-buffer write follows 1 cycle later with lb_row_sel = row-top and lb_wr_col = col.
  - Lasts 3*COLS+1 cycles, then go to CONV_GO.
  - All three rows are reloaded for every row-set; there is no row reuse.
- CONV_GO: conv_start=1 for exactly one cycle, conv_dest_base=out_row; go to CONV_WAIT.
- CONV_WAIT:
  - Hold until conv_done=1, then go to NEXT.
  - A conv_done that arrives in any other state is ignored.
- NEXT:
  - If out_row == N_OUT-1, go to FIN, where N_OUT = (IMG_ROWS-3)/stride + 1 (integer division).
  - Otherwise out_row++ and go to LOAD.
- FIN: done=1 for one cycle; go to IDLE.
- The start input is ignored while busy=1.
- Memory read enables never assert outside KLOAD and LOAD.
- A mid-pass reset aborts immediately; no writes occur after rst falls.
- Address arithmetic is computed at IMG_AW width; IMG_ROWS*COLS never overflows by parameter constraint.
- Total cycles from start to done = 1 + 10 + N_OUT*((3*COLS+1) + 1 + W + 1) + 1, where W is the convolve wait per row-set, counted in cycles from conv_start to conv_done.

Decomposition:
- Shared package conv_pkg holds:
  - FSM state enum;
  - KERNEL_TAPS=9;
  - stride encodings STRIDE_1=2'd1, STRIDE_2=2'd2;
  - the n_out(rows, stride) function.
- One sub-module, mem_row_loader: a generic "issue N sequential reads, write back with 1-cycle lag" engine with count, base address and done outputs. It is reused for both KLOAD and LOAD.

Test Plan:
- Reset and kernel load: assert reset mid-LOAD with IMG_ROWS=5, COLS=4 -> busy=0 and all outputs 0 the same cycle. Then issue start, stride 1, with kmem[i]=i+1 -> k_wr_data sequence 1..9 at addresses 0..8.
- Stride 1, IMG_ROWS=5, COLS=4, img[a]=a, convolve model returns done 3 cycles after start:
  - 3 conv_start pulses with dest_base 0, 1, 2;
  - the second LOAD writes data 4..15;
  - done fires 1+10+3*(13+1+3+1)+1=66 cycles after start.
- Stride 2, same image -> 2 row-sets; tops at rows 0 and 2; the second LOAD's first read address is 8; dest_base 0, 1.
- Illegal stride 0 and 3 -> err pulse, busy stays 0, no memory reads.
- start pulsed during CONV_WAIT, plus a spurious conv_done during LOAD -> both ignored; sequence and cycle count identical to the stride-1 case.
